child_dispatch_seq: RTL and testbench

- Parametrised successor to fixed five-child structural wrappers.
- Launches up to NUM_CHILD child blocks from one start request, in sequential or parallel mode, and collects their completion.
- Per-child enable mask, programmable timeout, single completion/error report upward.
- Sits between a parent hierarchy level and its child instances.

---
 rtl/child_dispatch_seq.sv | 151 +++++++++++++++
 tb/tb_child_dispatch_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_dispatch_seq.sv
// Child dispatcher: launches enabled child blocks sequentially or in parallel from one
// start request, collects their completion and reports done/timeout upward.
module child_dispatch_seq #(
    parameter int NUM_CHILD = 5,
    parameter int TIMEOUT_W = 8,
    parameter int ID_W      = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [NUM_CHILD-1:0] en_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic [NUM_CHILD-1:0] child_start_o,
    input  logic [NUM_CHILD-1:0] child_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [ID_W-1:0]      err_child_o,
    output logic [NUM_CHILD-1:0] done_mask_o,
    output logic [1:0]           dbg_state
);

    // Handshake: start_i is a request taken only when busy_o is low (IDLE); it is
    // dropped silently otherwise. done_o pulses once per accepted request, and
    // error_o/err_child_o/done_mask_o stay valid from that pulse until the next accept.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CHILD-1:0]   pending_q, pending_d;
    logic [NUM_CHILD-1:0]   done_mask_d;
    logic [NUM_CHILD-1:0]   start_d;
    logic                   mode_q, mode_d;
    logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]        cur_q, cur_d;
    logic                   error_d;
    logic [ID_W-1:0]        err_child_d;
    logic                   hit_seq;
    logic                   hit_par;
    logic                   timed_out;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_CHILD-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

    assign hit_seq   = child_done_i[cur_q];
    assign hit_par   = |(child_done_i & pending_q);
    assign timed_out = (timeout_q != '0) && (cnt_q == timeout_q - TIMEOUT_W'(1));
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        done_mask_d = done_mask_o;
        mode_d      = mode_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        error_d     = error_o;
        err_child_d = err_child_o;
        start_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pending_d   = en_mask_i;
                    mode_d      = mode_i;
                    timeout_d   = timeout_i;
                    done_mask_d = '0;
                    error_d     = 1'b0;
                    err_child_d = '0;
                    state_d     = (en_mask_i != '0) ? S_LAUNCH : S_FINISH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!mode_q && hit_seq) begin
                    done_mask_d[cur_q] = 1'b1;
                    pending_d[cur_q]   = 1'b0;
                    state_d            = (pending_d == '0) ? S_FINISH : S_LAUNCH;
                end else if (mode_q && hit_par) begin
                    done_mask_d = done_mask_o | (child_done_i & pending_q);
                    pending_d   = pending_q & ~child_done_i;
                    if (pending_d == '0) state_d = S_FINISH;
                end else if (timed_out) begin
                    // Completion has priority, so this branch only fires on a silent cycle.
                    error_d     = 1'b1;
                    err_child_d = mode_q ? lowest_idx(pending_q) : cur_q;
                    state_d     = S_FINISH;
                end else if (cnt_q != {TIMEOUT_W{1'b1}}) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start pulses are registered so they line up exactly with the LAUNCH state.
        if (state_d == S_LAUNCH) begin
            cur_d   = lowest_idx(pending_d);
            start_d = mode_d ? pending_d : (pending_d & (~pending_d + NUM_CHILD'(1)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            mode_q        <= 1'b0;
            timeout_q     <= '0;
            cnt_q         <= '0;
            cur_q         <= '0;
            child_start_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            err_child_o   <= '0;
            done_mask_o   <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
            cur_q         <= cur_d;
            child_start_o <= start_d;
            busy_o        <= (state_d != S_IDLE);
            done_o        <= (state_d == S_FINISH);
            error_o       <= error_d;
            err_child_o   <= err_child_d;
            done_mask_o   <= done_mask_d;
        end
    end

endmodule

// File: tb/tb_child_dispatch_seq.sv
// Bench for child_dispatch_seq: reactive child responders, an event-level model of each
// run, a per-cycle compare process and hand-computed completion cycles.
module tb_child_dispatch_seq;

    localparam int NC   = 5;
    localparam int TW   = 8;
    localparam int IW   = 3;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          mode_i;
    logic [NC-1:0] en_mask_i;
    logic [TW-1:0] timeout_i;
    logic [NC-1:0] child_start_o;
    logic [NC-1:0] child_done_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [IW-1:0] err_child_o;
    logic [NC-1:0] done_mask_o;
    logic [1:0]    dbg_state;

    child_dispatch_seq #(.NUM_CHILD(NC), .TIMEOUT_W(TW), .ID_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .en_mask_i    (en_mask_i),
        .timeout_i    (timeout_i),
        .child_start_o(child_start_o),
        .child_done_i (child_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .err_child_o  (err_child_o),
        .done_mask_o  (done_mask_o),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required end before 200000");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [NC-1:0] v);
        int r;
        r = 0;
        for (int i = NC - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // expected trace, indexed by cycle offset from the accept edge
    logic [NC-1:0] e_start [MAXC];
    logic [NC-1:0] e_mask  [MAXC];
    int            e_fin;
    logic          e_err;
    logic [IW-1:0] e_errc;

    int dly [NC];  // edges after a child's start pulse until it raises done; 0 = silent

    // A child answering d edges after launch is first seen in WAIT at max(d, 2);
    // a child has exactly t WAIT edges (launch+2 .. launch+1+t) to answer.
    task automatic model(input logic m, input logic [NC-1:0] mk, input int t);
        logic [NC-1:0] pend, dm, comp;
        int lch, ec, tedge, cnt, j;
        for (int o = 0; o < MAXC; o++) begin
            e_start[o] = '0;
            e_mask[o]  = '0;
        end
        e_err = 1'b0; e_errc = '0; e_fin = 0; pend = mk; dm = '0;
        if (mk != '0 && !m) begin
            lch = 0;
            while (pend != '0) begin
                j = lowest(pend);
                e_start[lch][j] = 1'b1;
                ec    = lch + ((dly[j] > 2) ? dly[j] : 2);
                tedge = lch + 1 + t;
                if (dly[j] == 0 || (t != 0 && ec > tedge)) begin
                    e_err = 1'b1; e_errc = IW'(j); e_fin = tedge; pend = '0;
                end else begin
                    dm[j] = 1'b1; pend[j] = 1'b0;
                    for (int o = ec; o < MAXC; o++) e_mask[o] = dm;
                    lch = ec; e_fin = ec;
                end
            end
        end else if (mk != '0) begin
            e_start[0] = mk;
            cnt = 0;
            for (int e = 2; e < MAXC - 2 && pend != '0; e++) begin
                comp = '0;
                for (int k = 0; k < NC; k++)
                    if (pend[k] && dly[k] != 0 && ((dly[k] > 2) ? dly[k] : 2) <= e) comp[k] = 1'b1;
                if (comp != '0) begin
                    dm = dm | comp; pend = pend & ~comp;
                    for (int o = e; o < MAXC; o++) e_mask[o] = dm;
                    if (pend == '0) e_fin = e;
                end else begin
                    cnt++;
                    if (t != 0 && cnt == t) begin
                        e_err = 1'b1; e_errc = IW'(lowest(pend)); e_fin = e; pend = '0;
                    end
                end
            end
        end
    endtask

    // child responders: level done, dropped when the child is started again
    int            run_id  = 0;
    int            seen_id = 0;
    int            st [NC];
    logic [NC-1:0] armed;

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id      = run_id;
            armed        = '0;
            child_done_i = '0;
        end
        for (int k = 0; k < NC; k++) begin
            if (child_start_o[k]) begin
                st[k] = cyc; armed[k] = 1'b1; child_done_i[k] = 1'b0;
            end
        end
        for (int k = 0; k < NC; k++)
            if (armed[k] && dly[k] != 0 && cyc + 1 >= st[k] + dly[k]) child_done_i[k] = 1'b1;
    end

    // compare process
    int win_lo  = 1;
    int win_hi  = 0;
    int got_fin = -1;

    always @(negedge clk) begin
        int o, fin;
        if (!rst && cyc >= win_lo && cyc <= win_hi) begin
            o   = cyc - win_lo;
            fin = win_hi - win_lo - 1;
            if (o == 0) got_fin = -1;
            chk("busy", 32'(busy_o), 32'(o <= fin));
            chk("done", 32'(done_o), 32'(o == fin));
            chk("child_start", 32'(child_start_o), 32'(e_start[o]));
            chk("error", 32'(error_o), (o >= fin) ? 32'(e_err) : 32'd0);
            chk("err_child", 32'(err_child_o), (o >= fin) ? 32'(e_errc) : 32'd0);
            chk("done_mask", 32'(done_mask_o), 32'(e_mask[o]));
            if (done_o) got_fin = o;
        end
    end

    // driver tasks
    task automatic set_dly(input int a, input int b, input int c, input int d, input int e);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d; dly[4] = e;
    endtask

    task automatic run(input logic m, input logic [NC-1:0] mk, input int t, input int hold);
        @(negedge clk);
        run_id++;
        model(m, mk, t);
        start_i = 1'b1; mode_i = m; en_mask_i = mk; timeout_i = TW'(t);
        win_lo = cyc + 1;
        win_hi = cyc + 1 + e_fin + 1;
        @(negedge clk);
        for (int h = 0; h < hold; h++) begin
            start_i = 1'b1; mode_i = ~m; timeout_i = 8'd1;
            en_mask_i = NC'($urandom_range(0, 31));
            @(negedge clk);
        end
        start_i = 1'b0; mode_i = 1'b0; en_mask_i = '0; timeout_i = '0;
        while (cyc < win_hi) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_start"}, 32'(child_start_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_errc"}, 32'(err_child_o), 32'd0);
        chk({tag, "_mask"}, 32'(done_mask_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; en_mask_i = '0; timeout_i = '0;
        child_done_i = '0; armed = '0;
        set_dly(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // sequential, ch1 -> ch2 -> ch4, 3 edges each
        set_dly(3, 3, 3, 3, 3);
        run(1'b0, 5'b10110, 0, 0);
        chk("t1_done_cycle", 32'(got_fin), 32'd9);
        chk("t1_mask_held", 32'(done_mask_o), 32'b10110);

        // parallel, slowest child at 7
        set_dly(2, 7, 4, 1, 5);
        run(1'b1, 5'b11111, 0, 0);
        chk("t2_done_cycle", 32'(got_fin), 32'd7);
        chk("t2_mask_held", 32'(done_mask_o), 32'b11111);

        // sequential timeout on silent ch0
        set_dly(0, 3, 3, 3, 3);
        run(1'b0, 5'b00011, 4, 0);
        chk("t3_done_cycle", 32'(got_fin), 32'd5);
        chk("t3_error", 32'(error_o), 32'd1);
        chk("t3_err_child", 32'(err_child_o), 32'd0);
        chk("t3_mask", 32'(done_mask_o), 32'd0);

        // empty mask
        run(1'b0, 5'b00000, 0, 0);
        chk("t4_done_cycle", 32'(got_fin), 32'd0);
        chk("t4_error_cleared", 32'(error_o), 32'd0);

        // completion on the last allowed WAIT edge
        set_dly(5, 0, 0, 0, 0);
        run(1'b0, 5'b00001, 4, 0);
        chk("t5_done_cycle", 32'(got_fin), 32'd5);
        chk("t5_no_error", 32'(error_o), 32'd0);
        chk("t5_mask", 32'(done_mask_o), 32'b00001);

        // parallel timeout with partial completion
        set_dly(2, 0, 3, 0, 0);
        run(1'b1, 5'b11111, 3, 0);
        chk("t6_done_cycle", 32'(got_fin), 32'd6);
        chk("t6_error_held", 32'(error_o), 32'd1);
        chk("t6_err_child", 32'(err_child_o), 32'd1);
        chk("t6_mask", 32'(done_mask_o), 32'b00101);

        // async reset mid-WAIT
        set_dly(0, 0, 0, 0, 0);
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b0; en_mask_i = 5'b00001; timeout_i = '0;
        @(negedge clk);
        start_i = 1'b0; en_mask_i = '0;
        chk("rw_launch", 32'(child_start_o), 32'b00001);
        repeat (3) @(negedge clk);
        chk("rw_busy_before", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_wait");
        @(negedge clk) rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rw_no_done", 32'(done_o), 32'd0);
            chk("rw_idle", 32'(busy_o), 32'd0);
        end

        // async reset during the launch pulse
        start_i = 1'b1; mode_i = 1'b1; en_mask_i = 5'b11111;
        @(negedge clk);
        start_i = 1'b0; mode_i = 1'b0; en_mask_i = '0;
        chk("rl_launch", 32'(child_start_o), 32'b11111);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_launch");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // start_i held with changing inputs while busy
        set_dly(3, 3, 0, 0, 0);
        run(1'b0, 5'b00011, 0, 5);
        chk("t7_done_cycle", 32'(got_fin), 32'd6);
        chk("t7_mask", 32'(done_mask_o), 32'b00011);

        // mixed runs
        for (int r = 0; r < 8; r++) begin
            int t;
            logic m;
            logic [NC-1:0] mk;
            m  = 1'($urandom_range(0, 1));
            mk = NC'($urandom_range(0, 31));
            t  = $urandom_range(0, 6);
            for (int k = 0; k < NC; k++) begin
                dly[k] = $urandom_range(0, 6);
                if (t == 0 && dly[k] == 0) dly[k] = 1;
            end
            run(m, mk, t, 0);
            chk("rand_done_seen", 32'(got_fin), 32'(e_fin));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
